// File: rtl/reg_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_wb_pkg
// Description : Shared widths and the write-back entry type for the
//               register-file write-back block.
// Revision    : 1.0
// ============================================================================
package reg_wb_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  localparam logic [REG_ADDR_W-1:0] X0 = '0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage : reg_wb_pkg
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo
// Description : Synchronous FIFO of write-back entries for long-latency results.
// Revision    : 1.0
// ============================================================================
module wb_fifo
  import reg_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  wb_entry_t din,
  input  logic      pop,
  output wb_entry_t dout,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  // Extra MSB on each pointer distinguishes full from empty.
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  wb_entry_t   r_mem [DEPTH];

  logic w_push_ok;
  logic w_pop_ok;

  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign empty = (r_wr_ptr == r_rd_ptr);

  // Illegal push/pop requests are dropped so the pointers stay coherent.
  assign w_push_ok = push && !full;
  assign w_pop_ok  = pop && !empty;

  assign dout = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

endmodule : wb_fifo
`default_nettype wire

// File: rtl/reg_writeback.sv
`default_nettype none
// ============================================================================
// Module      : reg_writeback
// Description : Merges ALU and long-latency results onto the register-file
//               write port and tracks pending long-latency destinations.
// Revision    : 1.0
// ============================================================================
module reg_writeback
  import reg_wb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  ll_valid,
  output logic                  ll_ready,
  input  logic [REG_ADDR_W-1:0] ll_rd,
  input  logic [XLEN-1:0]       ll_data,
  output logic                  RegWrite,
  output logic [REG_ADDR_W-1:0] target_reg,
  output logic [XLEN-1:0]       RegWrite_data
);

  wb_entry_t w_ll_in;
  wb_entry_t w_head;
  logic      w_full;
  logic      w_empty;
  logic      w_push;
  logic      w_pop;
  logic      w_retire_ll;

  logic                  r_we;
  logic [REG_ADDR_W-1:0] r_target;
  logic [XLEN-1:0]       r_data;
  logic                  r_from_ll;

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_nxt;

  assign ll_ready = !w_full;
  assign w_push   = ll_valid && !w_full;
  assign w_pop    = !alu_valid && !w_empty;
  assign w_ll_in  = '{rd: ll_rd, data: ll_data};

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (w_push),
    .din   (w_ll_in),
    .pop   (w_pop),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  // ALU has no backpressure, so it always wins the write port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_we      <= 1'b0;
      r_target  <= '0;
      r_data    <= '0;
      r_from_ll <= 1'b0;
    end else if (alu_valid) begin
      r_we      <= (alu_rd != X0);
      r_target  <= alu_rd;
      r_data    <= alu_data;
      r_from_ll <= 1'b0;
    end else if (w_pop) begin
      r_we      <= (w_head.rd != X0);
      r_target  <= w_head.rd;
      r_data    <= w_head.data;
      r_from_ll <= 1'b1;
    end else begin
      r_we      <= 1'b0;
      r_from_ll <= 1'b0;
    end
  end

  assign RegWrite      = r_we;
  assign target_reg    = r_target;
  assign RegWrite_data = r_data;

  assign w_retire_ll = r_we && r_from_ll;

  // A new issue to a register retiring on the same edge keeps it pending.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_retire_ll) begin
      w_busy_nxt[r_target] = 1'b0;
    end
    if (issue_valid) begin
      w_busy_nxt[issue_rd] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign rs1_busy = r_busy[rs1];
  assign rs2_busy = r_busy[rs2];

  a_issue_not_busy : assert property (@(posedge clk) disable iff (!reset)
    (issue_valid && issue_rd != X0) |->
      (!r_busy[issue_rd] || (w_retire_ll && r_target == issue_rd)));

  a_alu_not_busy : assert property (@(posedge clk) disable iff (!reset)
    (alu_valid && alu_rd != X0) |-> !r_busy[alu_rd]);

  a_ll_to_busy : assert property (@(posedge clk) disable iff (!reset)
    (ll_valid && ll_ready && ll_rd != X0) |-> r_busy[ll_rd]);

endmodule : reg_writeback
`default_nettype wire

// File: tb/tb_reg_writeback.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_writeback
// Description : Self-checking bench for reg_writeback against a queue-based
//               reference model of the write-back rules.
// Revision    : 1.0
// ============================================================================
module tb_reg_writeback;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ll_valid;
  logic        ll_ready;
  logic [4:0]  ll_rd;
  logic [31:0] ll_data;
  logic        RegWrite;
  logic [4:0]  target_reg;
  logic [31:0] RegWrite_data;

  reg_writeback #(.FIFO_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .issue_valid   (issue_valid),
    .issue_rd      (issue_rd),
    .rs1           (rs1),
    .rs2           (rs2),
    .rs1_busy      (rs1_busy),
    .rs2_busy      (rs2_busy),
    .alu_valid     (alu_valid),
    .alu_rd        (alu_rd),
    .alu_data      (alu_data),
    .ll_valid      (ll_valid),
    .ll_ready      (ll_ready),
    .ll_rd         (ll_rd),
    .ll_data       (ll_data),
    .RegWrite      (RegWrite),
    .target_reg    (target_reg),
    .RegWrite_data (RegWrite_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  // Reference model: result queue, pending set, and the visible write port.
  ent_t        mq[$];
  bit          m_busy[32];
  bit          m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  bit          m_ll;
  bit          last_acc;
  logic [4:0]  pending[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    pending.delete();
    for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    m_we = 1'b0; m_rd = '0; m_data = '0; m_ll = 1'b0; last_acc = 1'b0;
  endtask

  task automatic model_edge();
    bit   had_entry;
    bit   acc;
    ent_t e;
    had_entry = (mq.size() > 0);
    acc       = ll_valid && (mq.size() < DEPTH);
    if (m_we && m_ll) m_busy[m_rd] = 1'b0;
    if (issue_valid && issue_rd != 5'd0) m_busy[issue_rd] = 1'b1;
    if (alu_valid) begin
      m_we = (alu_rd != 5'd0); m_rd = alu_rd; m_data = alu_data; m_ll = 1'b0;
    end else if (had_entry) begin
      e = mq.pop_front();
      m_we = (e.rd != 5'd0); m_rd = e.rd; m_data = e.data; m_ll = 1'b1;
    end else begin
      m_we = 1'b0; m_ll = 1'b0;
    end
    if (acc) mq.push_back('{ll_rd, ll_data});
    last_acc = acc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    chk("RegWrite", RegWrite, m_we);
    if (m_we) begin
      chk("target_reg", target_reg, m_rd);
      chk("RegWrite_data", RegWrite_data, m_data);
    end
    chk("ll_ready", ll_ready, (mq.size() < DEPTH));
    chk("rs1_busy", rs1_busy, m_busy[rs1]);
    chk("rs2_busy", rs2_busy, m_busy[rs2]);
  endtask

  task automatic idle_inputs();
    issue_valid = 1'b0; issue_rd = '0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ll_valid = 1'b0; ll_rd = '0; ll_data = '0;
  endtask

  task automatic gen_random();
    int         idx;
    logic [4:0] r;
    if (ll_valid && last_acc) ll_valid = 1'b0;
    issue_valid = 1'b0;
    alu_valid   = 1'b0;
    if (!ll_valid && pending.size() > 0 && $urandom_range(0, 1) == 1) begin
      idx = $urandom_range(0, pending.size() - 1);
      ll_rd = pending[idx];
      pending.delete(idx);
      ll_data  = $urandom;
      ll_valid = 1'b1;
    end
    if ($urandom_range(0, 2) == 0) begin
      r = 5'($urandom_range(0, 31));
      if (!m_busy[r] && !(ll_valid && ll_rd == r && r != 5'd0)) begin
        issue_valid = 1'b1;
        issue_rd    = r;
        pending.push_back(r);
      end
    end
    if ($urandom_range(0, 9) < 6) begin
      r = 5'($urandom_range(0, 31));
      if (!m_busy[r] && !(issue_valid && issue_rd == r)) begin
        alu_valid = 1'b1;
        alu_rd    = r;
        alu_data  = $urandom;
      end
    end
    rs1 = 5'($urandom_range(0, 31));
    rs2 = 5'($urandom_range(0, 31));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [4:0] obs_rd[$];
    int         pushes;
    bit         full_seen;
    logic [4:0] free_rd;
    bit         found;

    model_reset();
    idle_inputs();
    rs1 = 5'd0; rs2 = 5'd1;
    reset = 1'b0;

    // Power-on reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_RegWrite", RegWrite, 1'b0);
    chk("rst_target", target_reg, 5'd0);
    chk("rst_data", RegWrite_data, 32'd0);
    chk("rst_ll_ready", ll_ready, 1'b1);
    reset = 1'b1;

    // ALU write path
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    step();
    chk("alu_we", RegWrite, 1'b1);
    chk("alu_rd", target_reg, 5'd5);
    chk("alu_data", RegWrite_data, 32'hDEADBEEF);
    alu_valid = 1'b0;
    step();

    // Long-latency write for rd 7 and its busy window
    rs1 = 5'd7;
    issue_valid = 1'b1; issue_rd = 5'd7;
    step();
    issue_valid = 1'b0;
    chk("rd7_busy_set", rs1_busy, 1'b1);
    step();
    ll_valid = 1'b1; ll_rd = 5'd7; ll_data = 32'h12345678;
    step();
    ll_valid = 1'b0;
    step();
    chk("rd7_we", RegWrite, 1'b1);
    chk("rd7_target", target_reg, 5'd7);
    chk("rd7_data", RegWrite_data, 32'h12345678);
    chk("rd7_busy_at_write", rs1_busy, 1'b1);
    step();
    chk("rd7_busy_cleared", rs1_busy, 1'b0);

    // Contention: ALU holds the port while five results queue up
    for (int i = 0; i < 5; i++) begin
      issue_valid = 1'b1; issue_rd = 5'(10 + i);
      step();
    end
    issue_valid = 1'b0;
    pushes = 0;
    full_seen = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      alu_valid = (cyc < 6);
      alu_rd    = 5'd20;
      alu_data  = $urandom;
      if (!ll_valid && pushes < 5) begin
        ll_valid = 1'b1; ll_rd = 5'(10 + pushes); ll_data = 32'hC0DE0000 + 32'(pushes);
      end
      step();
      if (RegWrite && target_reg >= 5'd10 && target_reg <= 5'd14) obs_rd.push_back(target_reg);
      if (ll_valid && last_acc) begin
        ll_valid = 1'b0;
        pushes++;
      end
      if (pushes == 4 && cyc < 5 && !full_seen) begin
        chk("fifo_full_ready", ll_ready, 1'b0);
        full_seen = 1'b1;
      end
    end
    alu_valid = 1'b0;
    chk("drain_count", obs_rd.size(), 5);
    for (int i = 0; i < obs_rd.size(); i++) chk("drain_order", obs_rd[i], 5'(10 + i));

    // x0 from both sources
    issue_valid = 1'b1; issue_rd = 5'd15;
    step();
    issue_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF0000;
    ll_valid = 1'b1; ll_rd = 5'd0; ll_data = 32'h0BADF00D;
    step();
    chk("x0_alu_no_we", RegWrite, 1'b0);
    alu_valid = 1'b0;
    ll_rd = 5'd15; ll_data = 32'h15151515;
    step();
    chk("x0_ll_no_we", RegWrite, 1'b0);
    ll_valid = 1'b0;
    step();
    chk("x0_popped_next_we", RegWrite, 1'b1);
    chk("x0_popped_next_rd", target_reg, 5'd15);
    step();

    // Same-edge retire and re-issue of rd 9
    rs1 = 5'd9;
    issue_valid = 1'b1; issue_rd = 5'd9;
    step();
    issue_valid = 1'b0;
    ll_valid = 1'b1; ll_rd = 5'd9; ll_data = 32'h99999999;
    step();
    ll_valid = 1'b0;
    step();
    chk("rd9_retiring", target_reg, 5'd9);
    issue_valid = 1'b1; issue_rd = 5'd9;
    step();
    issue_valid = 1'b0;
    chk("rd9_set_wins", rs1_busy, 1'b1);
    pending.push_back(5'd9);

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      gen_random();
      step();
    end

    // Asynchronous reset in the middle of traffic
    if (ll_valid && last_acc) ll_valid = 1'b0;
    issue_valid = 1'b0;
    found = 1'b0;
    free_rd = 5'd1;
    for (int r = 1; r < 32; r++) begin
      if (!found && !m_busy[r]) begin
        free_rd = 5'(r);
        found = 1'b1;
      end
    end
    alu_valid = found; alu_rd = free_rd; alu_data = 32'hA5A5A5A5;
    step();
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_RegWrite", RegWrite, 1'b0);
    chk("midrst_ll_ready", ll_ready, 1'b1);
    for (int r = 0; r < 32; r++) begin
      rs1 = 5'(r);
      #1;
      chk("midrst_rs1_busy", rs1_busy, 1'b0);
    end
    idle_inputs();
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;

    for (int n = 0; n < 400; n++) begin
      gen_random();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_reg_writeback
`default_nettype wire
